// File: rtl/apb_mem_slave.sv
// APB slave that turns each selected transfer into one strobe on a synchronous
// 8-bit memory port, with master-requested wait states and a one-cycle ready pulse.
module apb_mem_slave #(
    parameter logic [1:0] SLAVE_ID = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write,
    input  logic [1:0] sel,
    input  logic       enable,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] wait_cycles,
    output logic       ready,
    output logic [7:0] rdata,
    output logic       mem_clk,
    output logic       mem_ce,
    output logic       mem_wren,
    output logic       mem_rden,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_MEM,
        S_CAPT,
        S_RESP
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_write;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_wc;
    logic [7:0] r_cnt;
    logic [7:0] r_rdata;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;
    logic       w_sel;
    logic       w_latch;

    assign w_sel = (sel == SLAVE_ID);

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel && !enable) begin
                    w_latch = 1'b1;
                    w_next  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!w_sel) begin
                    w_next = S_IDLE;
                end else if (enable) begin
                    w_next = S_WAIT;
                end else begin
                    w_latch = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt == 8'd0) begin
                    w_next = S_MEM;
                end
            end
            S_MEM:  w_next = r_write ? S_RESP : S_CAPT;
            S_CAPT: w_next = S_RESP;
            S_RESP: begin
                // Setup presented during RESP chains straight into the next transfer.
                if (w_sel && !enable) begin
                    w_latch = 1'b1;
                    w_next  = S_SETUP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wc        <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_write <= write;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_wc    <= wait_cycles;
            end
            if (r_state == S_SETUP && w_sel && enable) begin
                r_cnt <= r_wc;
            end else if (r_state == S_WAIT && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            // Memory address/data registered on entry to MEM so they hold afterwards.
            if (r_state == S_WAIT && r_cnt == 8'd0) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= r_wdata;
            end
            if (r_state == S_CAPT) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign mem_clk   = clk;
    assign mem_ce    = (r_state == S_MEM);
    assign mem_wren  = (r_state == S_MEM) && r_write;
    assign mem_rden  = (r_state == S_MEM) && !r_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ready     = (r_state == S_RESP);
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave with a behavioural synchronous memory
// attached to the memory port.
module tb_apb_mem_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       enable = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] wait_cycles = '0;
    logic       ready;
    logic [7:0] rdata;
    logic       mem_clk;
    logic       mem_ce;
    logic       mem_wren;
    logic       mem_rden;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;

    apb_mem_slave #(.SLAVE_ID(2'b01)) dut (
        .clk(clk), .reset(reset), .write(write), .sel(sel), .enable(enable),
        .addr(addr), .wdata(wdata), .wait_cycles(wait_cycles), .ready(ready),
        .rdata(rdata), .mem_clk(mem_clk), .mem_ce(mem_ce), .mem_wren(mem_wren),
        .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_model [256];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rd = '0;

    always @(posedge clk) begin
        if (mem_ce && mem_wren) mem_model[mem_addr] <= mem_wdata;
        if (mem_ce && mem_rden) mem_rdata <= mem_model[mem_addr];
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  data;
        int unsigned strobe_cyc;
        int unsigned ready_cyc;
    } exp_t;

    exp_t sb[$];
    int tests_run = 0;
    int tests_failed = 0;

    task automatic drive_setup(input logic wr, input logic [1:0] s, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] w);
        sel = s; enable = 1'b0; write = wr; addr = a; wdata = d; wait_cycles = w;
    endtask

    task automatic start_setup(input logic wr, input logic [1:0] s, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] w);
        @(posedge clk); #1;
        drive_setup(wr, s, a, d, w);
    endtask

    // Access phase of the transfer whose setup is already on the bus; returns
    // at the negedge of the ready cycle with the bus still in access phase.
    task automatic run_access(input string name, input int unsigned budget);
        exp_t e;
        int unsigned strobes = 0;
        int unsigned strobe_at = 0;
        int unsigned rdy_at = 0;
        logic s_ce = 1'bx, s_wr = 1'bx, s_rd = 1'bx;
        logic [7:0] s_addr = 'x, s_data = 'x;
        e.wr = write;
        e.addr = addr;
        e.data = write ? wdata : ref_mem[addr];
        e.strobe_cyc = int'(wait_cycles) + 3;
        e.ready_cyc = int'(wait_cycles) + (write ? 4 : 5);
        if (write) ref_mem[addr] = wdata;
        sb.push_back(e);
        @(posedge clk); #1;
        enable = 1'b1;
        for (int unsigned n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (mem_ce || mem_wren || mem_rden) begin
                strobes++; strobe_at = n;
                s_ce = mem_ce; s_wr = mem_wren; s_rd = mem_rden;
                s_addr = mem_addr; s_data = mem_wdata;
            end
            if (ready) begin
                rdy_at = n;
                break;
            end
        end
        e = sb.pop_front();
        tests_run++;
        if (rdy_at !== e.ready_cyc) begin
            tests_failed++;
            $display("FAIL %s ready_cycle: got %0d expected %0d", name, rdy_at, e.ready_cyc);
        end
        tests_run++;
        if (strobes !== 1 || strobe_at !== e.strobe_cyc || s_ce !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s strobe: got count %0d at cycle %0d ce %b expected 1 at %0d ce 1",
                     name, strobes, strobe_at, s_ce, e.strobe_cyc);
        end
        tests_run++;
        if ({s_wr, s_rd} !== {e.wr, !e.wr} || s_addr !== e.addr) begin
            tests_failed++;
            $display("FAIL %s mem_cmd: got wren %b rden %b addr %h expected wren %b rden %b addr %h",
                     name, s_wr, s_rd, s_addr, e.wr, !e.wr, e.addr);
        end
        if (e.wr) begin
            tests_run++;
            if (s_data !== e.data) begin
                tests_failed++;
                $display("FAIL %s mem_wdata: got %h expected %h", name, s_data, e.data);
            end
        end else begin
            last_rd = e.data;
        end
        tests_run++;
        if (rdata !== last_rd || mem_addr !== e.addr) begin
            tests_failed++;
            $display("FAIL %s rdata/addr_hold: got rdata %h mem_addr %h expected %h %h",
                     name, rdata, mem_addr, last_rd, e.addr);
        end
    endtask

    task automatic idle_bus(input string name);
        sel = 2'b00; enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s ready_single: got %b expected 0", name, ready);
        end
    endtask

    task automatic watch_quiet(input string name, input int unsigned cycles);
        int unsigned hits = 0;
        for (int unsigned n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (mem_ce || mem_wren || mem_rden || ready) hits++;
        end
        tests_run++;
        if (hits !== 0) begin
            tests_failed++;
            $display("FAIL %s quiet: got %0d strobe/ready cycles expected 0", name, hits);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({ready, mem_ce, mem_wren, mem_rden} !== 4'b0000 ||
                rdata !== 8'h00 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_values: got rdy %b ce %b wr %b rd %b rdata %h addr %h wdata %h expected all 0",
                         ready, mem_ce, mem_wren, mem_rden, rdata, mem_addr, mem_wdata);
            end
        end
        tests_run++;
        if (mem_clk !== clk) begin
            tests_failed++;
            $display("FAIL mem_clk: got %b expected %b", mem_clk, clk);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_read;
        start_setup(1'b1, 2'b01, 8'h10, 8'hA5, 8'd0);
        run_access("wr_nowait", 20);
        idle_bus("wr_nowait");
        start_setup(1'b0, 2'b01, 8'h10, 8'h00, 8'd0);
        run_access("rd_nowait", 20);
        idle_bus("rd_nowait");
    endtask

    task automatic test_wait_states;
        start_setup(1'b0, 2'b01, 8'h10, 8'h00, 8'd3);
        run_access("rd_wait3", 30);
        idle_bus("rd_wait3");
        start_setup(1'b0, 2'b01, 8'h10, 8'h00, 8'd255);
        run_access("rd_wait255", 300);
        idle_bus("rd_wait255");
    endtask

    task automatic test_select;
        start_setup(1'b1, 2'b10, 8'h40, 8'h77, 8'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        watch_quiet("wrong_sel", 10);
        start_setup(1'b1, 2'b01, 8'h41, 8'h66, 8'd0);
        @(posedge clk); #1;
        sel = 2'b00;
        watch_quiet("abort_setup", 8);
        start_setup(1'b1, 2'b01, 8'h30, 8'h3C, 8'd1);
        run_access("after_abort", 20);
        idle_bus("after_abort");
    endtask

    task automatic test_back_to_back;
        start_setup(1'b1, 2'b01, 8'h20, 8'h5C, 8'd2);
        run_access("b2b_write", 20);
        drive_setup(1'b0, 2'b01, 8'h20, 8'h00, 8'd0);
        run_access("b2b_read", 20);
        idle_bus("b2b_read");
    endtask

    task automatic test_reset_mid;
        start_setup(1'b0, 2'b01, 8'h20, 8'h00, 8'd10);
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({ready, mem_ce, mem_wren, mem_rden} !== 4'b0000 ||
            rdata !== 8'h00 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid_values: got rdy %b ce %b rdata %h addr %h wdata %h expected all 0",
                     ready, mem_ce, rdata, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        sel = 2'b00; enable = 1'b0;
        last_rd = 8'h00;
        watch_quiet("reset_mid", 20);
        start_setup(1'b0, 2'b01, 8'h10, 8'h00, 8'd2);
        run_access("post_reset_rd", 20);
        idle_bus("post_reset_rd");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_write_read();
        test_wait_states();
        test_select();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
